psi_table_gen: RTL and testbench

Runtime-loadable, parametrised twiddle-factor table for the NTT datapath. After an `init` pulse it computes psi^k mod Q and psi^-k mod Q for k = 0..DEPTH-1 with one modular multiply per table per cycle, stores both tables, and serves registered single-port reads for the forward and inverse butterflies. It replaces fixed per-(N, Q) constant tables: any ring size and modulus is served from one block, with optional bit-reversed storage order.

---
 rtl/psi_table_gen.sv | 141 ++++++++++++++
 tb/tb_psi_table_gen.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/psi_table_gen.sv
// Runtime-loadable twiddle table: fills psi^k and psi^-k mod Q for k = 0..DEPTH-1
// after an init pulse, then serves registered single-port reads for both directions.
module psi_table_gen #(
    parameter int WIDTH  = 17,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int Q      = 65537,
    parameter int BITREV = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init,
    input  logic [WIDTH-1:0]  psi_in,
    input  logic [WIDTH-1:0]  psi_inv_in,
    output logic              busy,
    output logic              ready,
    input  logic              rd_en,
    input  logic              rd_inv,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;

    localparam logic [ADDR_W-1:0]  K_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [WIDTH-1:0]   ONE    = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] Q_EXT  = (2 * WIDTH)'(Q);

    // Full-width product reduced in the same cycle; result is always below Q.
    function automatic logic [WIDTH-1:0] mod_mul(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] prod;
        prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        return WIDTH'(prod % Q_EXT);
    endfunction

    function automatic logic [ADDR_W-1:0] bit_rev(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        r = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            r[i] = a[ADDR_W-1-i];
        end
        return r;
    endfunction

    logic [1:0]        r_state;
    logic              r_busy;
    logic              r_ready;
    logic [ADDR_W-1:0] r_k;
    logic [WIDTH-1:0]  r_psi;
    logic [WIDTH-1:0]  r_psi_inv;
    logic [WIDTH-1:0]  r_acc_f_p0;
    logic [WIDTH-1:0]  r_acc_i_p0;
    logic [WIDTH-1:0]  r_rd_data_p1;
    logic              r_rd_vld_p1;

    logic [WIDTH-1:0]  r_fwd_mem [DEPTH];
    logic [WIDTH-1:0]  r_inv_mem [DEPTH];

    logic              w_start;
    logic              w_filling;
    logic [ADDR_W-1:0] w_wr_addr;

    assign w_start   = init && ((r_state == ST_IDLE) || (r_state == ST_READY));
    assign w_filling = (r_state == ST_FILL);
    assign w_wr_addr = (BITREV != 0) ? bit_rev(r_k) : r_k;

    // Control path: state, handshake flags, fill index and the registered read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_ready      <= 1'b0;
            r_k          <= '0;
            r_rd_vld_p1  <= 1'b0;
            r_rd_data_p1 <= '0;
        end else begin
            r_rd_vld_p1 <= 1'b0;
            if (r_ready && rd_en) begin
                r_rd_vld_p1  <= 1'b1;
                r_rd_data_p1 <= rd_inv ? r_inv_mem[rd_addr] : r_fwd_mem[rd_addr];
            end

            case (r_state)
                ST_IDLE, ST_READY: begin
                    if (init) begin
                        r_state <= ST_FILL;
                        r_busy  <= 1'b1;
                        r_ready <= 1'b0;
                        r_k     <= '0;
                    end
                end
                ST_FILL: begin
                    if (r_k == K_LAST) begin
                        r_state <= ST_READY;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                        r_k     <= '0;
                    end else begin
                        r_k <= r_k + ADDR_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b0;
                    r_k     <= '0;
                end
            endcase
        end
    end

    // p0: operand latch and running powers; restarted from 1 on every accepted init.
    always_ff @(posedge clk) begin
        if (w_start) begin
            r_psi      <= psi_in;
            r_psi_inv  <= psi_inv_in;
            r_acc_f_p0 <= ONE;
            r_acc_i_p0 <= ONE;
        end else if (w_filling) begin
            r_acc_f_p0 <= mod_mul(r_acc_f_p0, r_psi);
            r_acc_i_p0 <= mod_mul(r_acc_i_p0, r_psi_inv);
        end
    end

    always_ff @(posedge clk) begin
        if (w_filling) begin
            r_fwd_mem[w_wr_addr] <= r_acc_f_p0;
            r_inv_mem[w_wr_addr] <= r_acc_i_p0;
        end
    end

    assign busy     = r_busy;
    assign ready    = r_ready;
    assign rd_data  = r_rd_data_p1;
    assign rd_valid = r_rd_vld_p1;

endmodule

// File: tb/tb_psi_table_gen.sv
// Scoreboarded bench for psi_table_gen: linear and bit-reversed Q=257 tables plus a default Q=65537 table.
module tb_psi_table_gen;

    localparam int W  = 17;
    localparam int AW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]    rst_n;
    logic [2:0]    init;
    logic [2:0]    busy;
    logic [2:0]    ready;
    logic [2:0]    rd_en;
    logic [2:0]    rd_inv;
    logic [2:0]    rd_valid;
    logic [W-1:0]  psi      [3];
    logic [W-1:0]  psi_inv  [3];
    logic [W-1:0]  rd_data  [3];
    logic [AW-1:0] rd_addr  [3];

    int errors = 0;
    int checks = 0;
    int len;

    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    logic [W-1:0] q2[$];

    psi_table_gen #(.WIDTH(W), .DEPTH(16), .Q(257), .BITREV(0)) u_lin (
        .clk(clk), .rst_n(rst_n[0]), .init(init[0]), .psi_in(psi[0]), .psi_inv_in(psi_inv[0]),
        .busy(busy[0]), .ready(ready[0]), .rd_en(rd_en[0]), .rd_inv(rd_inv[0]),
        .rd_addr(rd_addr[0]), .rd_data(rd_data[0]), .rd_valid(rd_valid[0])
    );

    psi_table_gen #(.WIDTH(W), .DEPTH(16), .Q(257), .BITREV(1)) u_rev (
        .clk(clk), .rst_n(rst_n[1]), .init(init[1]), .psi_in(psi[1]), .psi_inv_in(psi_inv[1]),
        .busy(busy[1]), .ready(ready[1]), .rd_en(rd_en[1]), .rd_inv(rd_inv[1]),
        .rd_addr(rd_addr[1]), .rd_data(rd_data[1]), .rd_valid(rd_valid[1])
    );

    psi_table_gen #(.WIDTH(W)) u_dflt (
        .clk(clk), .rst_n(rst_n[2]), .init(init[2]), .psi_in(psi[2]), .psi_inv_in(psi_inv[2]),
        .busy(busy[2]), .ready(ready[2]), .rd_en(rd_en[2]), .rd_inv(rd_inv[2]),
        .rd_addr(rd_addr[2]), .rd_data(rd_data[2]), .rd_valid(rd_valid[2])
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int d, input int e);
        case (d)
            0:       q0.push_back(W'(e));
            1:       q1.push_back(W'(e));
            default: q2.push_back(W'(e));
        endcase
    endtask

    task automatic mon(input int d, input logic [W-1:0] act);
        logic [W-1:0] e;
        int n;
        case (d)
            0:       n = q0.size();
            1:       n = q1.size();
            default: n = q2.size();
        endcase
        if (n == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_unexpected_dut%0d: got rd_valid with rd_data=%0d, expected no read", d, act);
        end else begin
            case (d)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            check($sformatf("rd_data_dut%0d", d), int'(act), int'(e));
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rd_valid[d] === 1'b1) mon(d, rd_data[d]);
        end
    end

    task automatic rd(input int d, input bit inv, input int addr, input int exp);
        rd_en[d]   = 1'b1;
        rd_inv[d]  = inv;
        rd_addr[d] = AW'(addr);
        push(d, exp);
        @(negedge clk);
    endtask

    task automatic rd_stop(input int d);
        rd_en[d] = 1'b0;
        @(negedge clk);
    endtask

    task automatic count_busy(input int d, input int p, input int poke, output int n);
        n = 0;
        while (busy[d] === 1'b1 && n < 100) begin
            n++;
            if (n == poke) begin
                init[d]    = 1'b1;
                rd_en[d]   = 1'b1;
                rd_addr[d] = '0;
                psi[d]     = W'(3);
            end else if (n == poke + 1) begin
                init[d]  = 1'b0;
                rd_en[d] = 1'b0;
                psi[d]   = W'(p);
                check("fill_rd_ignored", int'(rd_valid[d]), 0);
            end
            @(negedge clk);
        end
    endtask

    task automatic fill(input logic [2:0] m, input int d, input int p, input int pi,
                        input int poke, output int n);
        for (int i = 0; i < 3; i++) begin
            if (m[i]) begin
                psi[i]     = W'(p);
                psi_inv[i] = W'(pi);
            end
        end
        init = init | m;
        @(negedge clk);
        init = init & ~m;
        count_busy(d, p, poke, n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 3'b000;
        init   = 3'b000;
        rd_en  = 3'b000;
        rd_inv = 3'b000;
        for (int i = 0; i < 3; i++) begin
            psi[i]     = '0;
            psi_inv[i] = '0;
            rd_addr[i] = '0;
        end
        repeat (2) @(negedge clk);
        rst_n = 3'b111;

        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_busy_dut%0d", d), int'(busy[d]), 0);
            check($sformatf("reset_ready_dut%0d", d), int'(ready[d]), 0);
        end

        // Reads before any fill must be ignored
        rd_en[0]   = 1'b1;
        rd_addr[0] = 4'd3;
        repeat (3) begin
            @(negedge clk);
            check("idle_busy", int'(busy[0]), 0);
            check("idle_ready", int'(ready[0]), 0);
            check("idle_rd_valid", int'(rd_valid[0]), 0);
            check("idle_rd_data", int'(rd_data[0]), 0);
        end
        rd_en[0] = 1'b0;
        @(negedge clk);

        // Q=257 linear and bit-reversed tables filled together
        fill(3'b011, 0, 136, 240, 1000, len);
        check("fill_len", len, 16);
        check("fill_ready_lin", int'(ready[0]), 1);
        check("fill_ready_rev", int'(ready[1]), 1);
        check("fill_busy_done", int'(busy[0]), 0);

        rd(0, 1'b0, 0, 1);
        rd(0, 1'b0, 1, 136);
        rd(0, 1'b0, 2, 249);
        rd(0, 1'b0, 8, 241);
        rd(0, 1'b1, 1, 240);
        rd(0, 1'b1, 2, 32);
        rd(0, 1'b1, 8, 16);
        rd_stop(0);
        check("hold_rd_valid", int'(rd_valid[0]), 0);
        check("hold_rd_data", int'(rd_data[0]), 16);

        rd(1, 1'b0, 1, 241);
        rd(1, 1'b0, 8, 136);
        rd(1, 1'b1, 1, 16);
        rd(1, 1'b0, 0, 1);
        rd(1, 1'b0, 4, 249);
        rd_stop(1);

        // Read and init in the same READY cycle, then a mid-fill init/read poke
        rd_en[0]   = 1'b1;
        rd_inv[0]  = 1'b0;
        rd_addr[0] = 4'd1;
        push(0, 136);
        psi[0]     = W'(136);
        psi_inv[0] = W'(240);
        init[0]    = 1'b1;
        @(negedge clk);
        init[0]  = 1'b0;
        rd_en[0] = 1'b0;
        check("rw_same_valid", int'(rd_valid[0]), 1);
        check("rw_same_ready", int'(ready[0]), 0);
        count_busy(0, 136, 3, len);
        check("refill_len", len, 16);
        check("refill_ready", int'(ready[0]), 1);
        rd(0, 1'b0, 2, 249);
        rd(0, 1'b1, 2, 32);
        rd_stop(0);

        // Asynchronous reset in the middle of a fill
        psi[0]     = W'(136);
        psi_inv[0] = W'(240);
        init[0]    = 1'b1;
        @(negedge clk);
        init[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("midfill_busy_before", int'(busy[0]), 1);
        rst_n[0] = 1'b0;
        #1;
        check("midfill_rst_busy", int'(busy[0]), 0);
        check("midfill_rst_ready", int'(ready[0]), 0);
        check("midfill_rst_rd_valid", int'(rd_valid[0]), 0);
        check("midfill_rst_rd_data", int'(rd_data[0]), 0);
        @(negedge clk);
        rst_n[0]   = 1'b1;
        rd_en[0]   = 1'b1;
        rd_addr[0] = 4'd8;
        repeat (2) begin
            @(negedge clk);
            check("post_rst_ready", int'(ready[0]), 0);
            check("post_rst_rd_valid", int'(rd_valid[0]), 0);
        end
        rd_en[0] = 1'b0;
        @(negedge clk);
        fill(3'b001, 0, 136, 240, 1000, len);
        check("post_rst_fill_len", len, 16);
        rd(0, 1'b0, 8, 241);
        rd_stop(0);

        // Default Q=65537: unit root, then psi=3
        fill(3'b100, 2, 1, 1, 1000, len);
        check("dflt_fill_len", len, 16);
        for (int a = 0; a < 16; a++) begin
            rd(2, 1'b0, a, 1);
            rd(2, 1'b1, a, 1);
        end
        rd_stop(2);
        fill(3'b100, 2, 3, 21846, 1000, len);
        check("dflt_refill_len", len, 16);
        rd(2, 1'b0, 2, 9);
        rd(2, 1'b1, 1, 21846);
        rd(2, 1'b0, 3, 27);
        rd_stop(2);

        @(negedge clk);
        check("pending_dut0", q0.size(), 0);
        check("pending_dut1", q1.size(), 0);
        check("pending_dut2", q2.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
